// File: rtl/fam_pkg.sv
// Shared definitions for the FAM edge dispatcher: default widths, lane count
// and the dispatcher state encoding.
package fam_pkg;

  localparam int DEF_ADDRW  = 16;
  localparam int DEF_WL     = 32;
  localparam int DEF_NUMFAM = 8;
  localparam int FAMBITS    = $clog2(DEF_NUMFAM);
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } disp_state_e;

endpackage

// File: rtl/fam_lane_buffer.sv
// One FAM's staging logic: three holding slots, a fill count and the 4-lane
// output register. A bundle is emitted when the fourth edge arrives or when
// the pass is flushed. Emitted lanes stay registered while ena is low and are
// presented on the first enabled cycle.
module fam_lane_buffer
  import fam_pkg::*;
#(
  parameter int ADDRW = DEF_ADDRW,
  parameter int WL    = DEF_WL
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             ena_i,
  input  logic                             clear_i,
  input  logic                             push_i,
  input  logic                             flush_i,
  input  logic [ADDRW-1:0]                 src_i,
  input  logic [ADDRW-1:0]                 dst_i,
  input  logic [WL-1:0]                    value_i,
  output logic [LANES-1:0][ADDRW-1:0]      src_o,
  output logic [LANES-1:0][ADDRW-1:0]      dst_o,
  output logic [LANES-1:0][WL-1:0]         value_o,
  output logic [LANES-1:0]                 valid_o
);

  logic [1:0]                   cnt_q, cnt_d;
  logic [2:0][ADDRW-1:0]        slot_src_q, slot_src_d;
  logic [2:0][ADDRW-1:0]        slot_dst_q, slot_dst_d;
  logic [2:0][WL-1:0]           slot_val_q, slot_val_d;
  logic [LANES-1:0][ADDRW-1:0]  out_src_q, out_src_d;
  logic [LANES-1:0][ADDRW-1:0]  out_dst_q, out_dst_d;
  logic [LANES-1:0][WL-1:0]     out_val_q, out_val_d;
  logic [LANES-1:0]             out_vld_q, out_vld_d;
  logic                         emit_s;

  // Next-state for slots, fill count and the output bundle.
  always_comb begin
    cnt_d      = cnt_q;
    slot_src_d = slot_src_q;
    slot_dst_d = slot_dst_q;
    slot_val_d = slot_val_q;
    out_src_d  = out_src_q;
    out_dst_d  = out_dst_q;
    out_val_d  = out_val_q;
    out_vld_d  = out_vld_q;
    emit_s     = 1'b0;
    if (ena_i) begin
      // An enabled cycle consumes whatever bundle was pending.
      out_src_d = '0;
      out_dst_d = '0;
      out_val_d = '0;
      out_vld_d = '0;
      if (clear_i) begin
        cnt_d = 2'd0;
      end else begin
        emit_s = (push_i && ((cnt_q == 2'd3) || flush_i)) ||
                 (flush_i && (cnt_q != 2'd0));
        if (emit_s) begin
          // Staged edges keep arrival order in lanes 0..cnt-1.
          for (int i = 0; i < 3; i++) begin
            if (2'(i) < cnt_q) begin
              out_src_d[i] = slot_src_q[i];
              out_dst_d[i] = slot_dst_q[i];
              out_val_d[i] = slot_val_q[i];
              out_vld_d[i] = 1'b1;
            end else begin
              out_vld_d[i] = 1'b0;
            end
          end
          // The incoming edge, if any, lands right after the staged ones.
          if (push_i) begin
            out_src_d[cnt_q] = src_i;
            out_dst_d[cnt_q] = dst_i;
            out_val_d[cnt_q] = value_i;
            out_vld_d[cnt_q] = 1'b1;
          end else begin
            out_vld_d[cnt_q] = 1'b0;
          end
          cnt_d = 2'd0;
        end else if (push_i) begin
          slot_src_d[cnt_q] = src_i;
          slot_dst_d[cnt_q] = dst_i;
          slot_val_d[cnt_q] = value_i;
          cnt_d             = cnt_q + 2'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset; reset discards staged edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= 2'd0;
      slot_src_q <= '0;
      slot_dst_q <= '0;
      slot_val_q <= '0;
      out_src_q  <= '0;
      out_dst_q  <= '0;
      out_val_q  <= '0;
      out_vld_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      slot_src_q <= slot_src_d;
      slot_dst_q <= slot_dst_d;
      slot_val_q <= slot_val_d;
      out_src_q  <= out_src_d;
      out_dst_q  <= out_dst_d;
      out_val_q  <= out_val_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign src_o   = out_src_q;
  assign dst_o   = out_dst_q;
  assign value_o = out_val_q;
  assign valid_o = out_vld_q & {LANES{ena_i}};

endmodule

// File: rtl/fam_edge_dispatcher.sv
// Serial edge stream to multi-FAM packed lane dispatcher. Routes each edge by
// the low destination bits to one of NUMFAM lane buffers and runs the
// IDLE/RUN/DONE pass control.
module fam_edge_dispatcher
  import fam_pkg::*;
#(
  parameter int ADDRW  = DEF_ADDRW,
  parameter int WL     = DEF_WL,
  parameter int NUMFAM = DEF_NUMFAM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      start,
  input  logic [ADDRW-1:0]          in_src,
  input  logic [ADDRW-1:0]          in_dst,
  input  logic [WL-1:0]             in_value,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [ADDRW*NUMFAM-1:0]   src0,
  output logic [ADDRW*NUMFAM-1:0]   src1,
  output logic [ADDRW*NUMFAM-1:0]   src2,
  output logic [ADDRW*NUMFAM-1:0]   src3,
  output logic [ADDRW*NUMFAM-1:0]   dst0,
  output logic [ADDRW*NUMFAM-1:0]   dst1,
  output logic [ADDRW*NUMFAM-1:0]   dst2,
  output logic [ADDRW*NUMFAM-1:0]   dst3,
  output logic [WL*NUMFAM-1:0]      value0,
  output logic [WL*NUMFAM-1:0]      value1,
  output logic [WL*NUMFAM-1:0]      value2,
  output logic [WL*NUMFAM-1:0]      value3,
  output logic [NUMFAM-1:0]         valid0,
  output logic [NUMFAM-1:0]         valid1,
  output logic [NUMFAM-1:0]         valid2,
  output logic [NUMFAM-1:0]         valid3,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               edge_count
);

  localparam int FB = $clog2(NUMFAM);

  disp_state_e  state_q, state_d;
  logic         accept_s, last_s, clear_s;
  logic [FB-1:0]     fam_s;
  logic [ADDRW-1:0]  dst_fwd_s;
  logic [31:0]       edge_count_q;

  logic [NUMFAM-1:0][LANES-1:0][ADDRW-1:0] lane_src_s;
  logic [NUMFAM-1:0][LANES-1:0][ADDRW-1:0] lane_dst_s;
  logic [NUMFAM-1:0][LANES-1:0][WL-1:0]    lane_val_s;
  logic [NUMFAM-1:0][LANES-1:0]            lane_vld_s;

  assign accept_s   = in_valid & in_ready;
  assign last_s     = accept_s & in_last;
  assign clear_s    = ena & start & (state_q == ST_IDLE);
  assign fam_s      = in_dst[FB-1:0];
  assign dst_fwd_s  = in_dst >> FB;
  assign edge_count = edge_count_q;

  // Pass state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pass state transitions; a last-edge accept implies ena.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ena && start) state_d = ST_RUN;
        else              state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_RUN;
      end
      ST_DONE: begin
        if (ena) state_d = ST_IDLE;
        else     state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the pass state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b0;
      end
      ST_RUN: begin
        in_ready = ena;
        busy     = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = ena;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Edge counter: cleared when a pass starts, wraps on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_count_q <= 32'd0;
    end else if (clear_s) begin
      edge_count_q <= 32'd0;
    end else if (accept_s) begin
      edge_count_q <= edge_count_q + 32'd1;
    end else begin
      edge_count_q <= edge_count_q;
    end
  end

  for (genvar g = 0; g < NUMFAM; g++) begin : g_fam
    fam_lane_buffer #(
      .ADDRW (ADDRW),
      .WL    (WL)
    ) u_buf (
      .clk_i   (clk),
      .rst_i   (rst),
      .ena_i   (ena),
      .clear_i (clear_s),
      .push_i  (accept_s && (fam_s == FB'(g))),
      .flush_i (last_s),
      .src_i   (in_src),
      .dst_i   (dst_fwd_s),
      .value_i (in_value),
      .src_o   (lane_src_s[g]),
      .dst_o   (lane_dst_s[g]),
      .value_o (lane_val_s[g]),
      .valid_o (lane_vld_s[g])
    );

    assign src0[ADDRW*g +: ADDRW] = lane_src_s[g][0];
    assign src1[ADDRW*g +: ADDRW] = lane_src_s[g][1];
    assign src2[ADDRW*g +: ADDRW] = lane_src_s[g][2];
    assign src3[ADDRW*g +: ADDRW] = lane_src_s[g][3];
    assign dst0[ADDRW*g +: ADDRW] = lane_dst_s[g][0];
    assign dst1[ADDRW*g +: ADDRW] = lane_dst_s[g][1];
    assign dst2[ADDRW*g +: ADDRW] = lane_dst_s[g][2];
    assign dst3[ADDRW*g +: ADDRW] = lane_dst_s[g][3];
    assign value0[WL*g +: WL]     = lane_val_s[g][0];
    assign value1[WL*g +: WL]     = lane_val_s[g][1];
    assign value2[WL*g +: WL]     = lane_val_s[g][2];
    assign value3[WL*g +: WL]     = lane_val_s[g][3];
    assign valid0[g]              = lane_vld_s[g][0];
    assign valid1[g]              = lane_vld_s[g][1];
    assign valid2[g]              = lane_vld_s[g][2];
    assign valid3[g]              = lane_vld_s[g][3];
  end

endmodule

// File: tb/tb_fam_edge_dispatcher.sv
// Directed, table-driven bench for fam_edge_dispatcher (NUMFAM=8, ADDRW=16, WL=32).
// Each table row is one clock cycle: inputs applied after the falling edge and
// the outputs expected in that same cycle.
module tb_fam_edge_dispatcher;

  logic clk, rst, ena, start, in_valid, in_last;
  logic [15:0] in_src, in_dst;
  logic [31:0] in_value;
  logic in_ready, busy, done;
  logic [31:0] edge_count;
  logic [127:0] src0, src1, src2, src3, dst0, dst1, dst2, dst3;
  logic [255:0] value0, value1, value2, value3;
  logic [7:0] valid0, valid1, valid2, valid3;

  logic [3:0][127:0] src_all, dst_all;
  logic [3:0][255:0] val_all;
  logic [31:0] vmask;

  assign src_all = {src3, src2, src1, src0};
  assign dst_all = {dst3, dst2, dst1, dst0};
  assign val_all = {value3, value2, value1, value0};
  assign vmask   = {valid3, valid2, valid1, valid0};

  fam_edge_dispatcher dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
    .in_src(in_src), .in_dst(in_dst), .in_value(in_value),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .dst0(dst0), .dst1(dst1), .dst2(dst2), .dst3(dst3),
    .value0(value0), .value1(value1), .value2(value2), .value3(value3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .busy(busy), .done(done), .edge_count(edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, ena, start, iv, il;
    logic [15:0] dst;
    logic [31:0] val;
    logic rdy, busy, done;
    logic [31:0] cnt;
    logic [31:0] vm;
    logic chk;
    int fam;
    logic [3:0][15:0] edst;
    logic [3:0][31:0] evl;
  } vec_t;

  vec_t vecs [0:127];
  int nvec = 0;
  int applied = 0;
  int miscompares = 0;

  task automatic v(input logic r, input logic e, input logic s, input logic iv,
                   input logic il, input logic [15:0] d, input logic [31:0] x,
                   input logic rdy, input logic b, input logic dn,
                   input logic [31:0] c, input logic [31:0] vm);
    vecs[nvec].rst = r;   vecs[nvec].ena = e;  vecs[nvec].start = s;
    vecs[nvec].iv = iv;   vecs[nvec].il = il;  vecs[nvec].dst = d;
    vecs[nvec].val = x;   vecs[nvec].rdy = rdy; vecs[nvec].busy = b;
    vecs[nvec].done = dn; vecs[nvec].cnt = c;  vecs[nvec].vm = vm;
    vecs[nvec].chk = 1'b0; vecs[nvec].fam = 0;
    vecs[nvec].edst = '0; vecs[nvec].evl = '0;
    nvec++;
  endtask

  // Attach an expected lane bundle for one FAM to the most recent row.
  task automatic ln(input int f, input logic [15:0] d0, input logic [15:0] d1,
                    input logic [15:0] d2, input logic [15:0] d3,
                    input logic [31:0] x0, input logic [31:0] x1,
                    input logic [31:0] x2, input logic [31:0] x3);
    vecs[nvec-1].chk = 1'b1;
    vecs[nvec-1].fam = f;
    vecs[nvec-1].edst = {d3, d2, d1, d0};
    vecs[nvec-1].evl = {x3, x2, x1, x0};
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
      miscompares++;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic iv,
                       input logic il, input logic [15:0] d, input logic [31:0] x);
    rst = r; ena = e; start = s; in_valid = iv; in_last = il;
    in_dst = d; in_value = x; in_src = x[15:0] ^ 16'h5a5a;
  endtask

  initial begin
    logic [15:0] esrc;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
    repeat (2) @(posedge clk);

    // reset state
    v(1,0,0,0,0, 16'd0, 32'd0,   0,0,0, 32'd0, 32'h0);
    // four edges to FAM3
    v(0,1,1,0,0, 16'd0, 32'd0,   0,0,0, 32'd0, 32'h0);
    v(0,1,0,1,0, 16'd3, 32'd1,   1,1,0, 32'd0, 32'h0);
    v(0,1,0,1,0, 16'd11, 32'd2,  1,1,0, 32'd1, 32'h0);
    v(0,1,0,1,0, 16'd19, 32'd3,  1,1,0, 32'd2, 32'h0);
    v(0,1,0,1,0, 16'd27, 32'd4,  1,1,0, 32'd3, 32'h0);
    v(0,1,0,0,0, 16'd0, 32'd0,   1,1,0, 32'd4, 32'h08080808);
    ln(3, 16'd0, 16'd1, 16'd2, 16'd3, 32'd1, 32'd2, 32'd3, 32'd4);
    v(0,1,0,0,0, 16'd0, 32'd0,   1,1,0, 32'd4, 32'h0);
    // FAM0 / FAM1 interleaved
    v(0,1,0,1,0, 16'd0,  32'd10, 1,1,0, 32'd4, 32'h0);
    v(0,1,0,1,0, 16'd1,  32'd11, 1,1,0, 32'd5, 32'h0);
    v(0,1,0,1,0, 16'd8,  32'd12, 1,1,0, 32'd6, 32'h0);
    v(0,1,0,1,0, 16'd9,  32'd13, 1,1,0, 32'd7, 32'h0);
    v(0,1,0,1,0, 16'd16, 32'd14, 1,1,0, 32'd8, 32'h0);
    v(0,1,0,1,0, 16'd17, 32'd15, 1,1,0, 32'd9, 32'h0);
    v(0,1,0,1,0, 16'd24, 32'd16, 1,1,0, 32'd10, 32'h0);
    v(0,1,0,1,0, 16'd25, 32'd17, 1,1,0, 32'd11, 32'h01010101);
    ln(0, 16'd0, 16'd1, 16'd2, 16'd3, 32'd10, 32'd12, 32'd14, 32'd16);
    v(0,1,0,0,0, 16'd0, 32'd0,   1,1,0, 32'd12, 32'h02020202);
    ln(1, 16'd0, 16'd1, 16'd2, 16'd3, 32'd11, 32'd13, 32'd15, 32'd17);
    v(0,1,0,0,0, 16'd0, 32'd0,   1,1,0, 32'd12, 32'h0);
    // start during RUN is ignored
    v(0,1,1,0,0, 16'd0, 32'd0,   1,1,0, 32'd12, 32'h0);
    v(0,1,0,1,1, 16'd6, 32'd30,  1,1,0, 32'd12, 32'h0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,1,1, 32'd13, 32'h00000040);
    ln(6, 16'd0, 16'd0, 16'd0, 16'd0, 32'd30, 32'd0, 32'd0, 32'd0);
    // edges in IDLE are not accepted
    v(0,1,0,1,0, 16'd0, 32'd99,  0,0,0, 32'd13, 32'h0);
    v(0,1,0,1,1, 16'd0, 32'd98,  0,0,0, 32'd13, 32'h0);
    // partial flush across two FAMs
    v(0,1,1,0,0, 16'd0, 32'd0,   0,0,0, 32'd13, 32'h0);
    v(0,1,0,1,0, 16'd5,  32'd20, 1,1,0, 32'd0, 32'h0);
    v(0,1,0,1,0, 16'd13, 32'd21, 1,1,0, 32'd1, 32'h0);
    v(0,1,0,1,1, 16'd2,  32'd22, 1,1,0, 32'd2, 32'h0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,1,1, 32'd3, 32'h00002024);
    ln(5, 16'd0, 16'd1, 16'd0, 16'd0, 32'd20, 32'd21, 32'd0, 32'd0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,0,0, 32'd3, 32'h0);
    // reset in the middle of a pass discards staged edges
    v(0,1,1,0,0, 16'd0, 32'd0,   0,0,0, 32'd3, 32'h0);
    v(0,1,0,1,0, 16'd0,  32'd40, 1,1,0, 32'd0, 32'h0);
    v(0,1,0,1,0, 16'd8,  32'd41, 1,1,0, 32'd1, 32'h0);
    v(0,1,0,1,0, 16'd16, 32'd42, 1,1,0, 32'd2, 32'h0);
    v(1,1,0,0,0, 16'd0, 32'd0,   1,1,0, 32'd3, 32'h0);
    v(0,1,0,1,0, 16'd24, 32'd43, 0,0,0, 32'd0, 32'h0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,0,0, 32'd0, 32'h0);
    v(0,1,1,0,0, 16'd0, 32'd0,   0,0,0, 32'd0, 32'h0);
    v(0,1,0,1,1, 16'd24, 32'd43, 1,1,0, 32'd0, 32'h0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,1,1, 32'd1, 32'h00000001);
    ln(0, 16'd3, 16'd0, 16'd0, 16'd0, 32'd43, 32'd0, 32'd0, 32'd0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,0,0, 32'd1, 32'h0);
    // ena low right after a completing fourth edge
    v(0,1,1,0,0, 16'd0, 32'd0,   0,0,0, 32'd1, 32'h0);
    v(0,1,0,1,0, 16'd4,  32'd50, 1,1,0, 32'd0, 32'h0);
    v(0,1,0,1,0, 16'd12, 32'd51, 1,1,0, 32'd1, 32'h0);
    v(0,1,0,1,0, 16'd20, 32'd52, 1,1,0, 32'd2, 32'h0);
    v(0,1,0,1,0, 16'd28, 32'd53, 1,1,0, 32'd3, 32'h0);
    v(0,0,0,1,0, 16'd4,  32'd60, 0,1,0, 32'd4, 32'h0);
    v(0,0,0,1,0, 16'd4,  32'd61, 0,1,0, 32'd4, 32'h0);
    v(0,0,0,0,0, 16'd0, 32'd0,   0,1,0, 32'd4, 32'h0);
    v(0,1,0,0,0, 16'd0, 32'd0,   1,1,0, 32'd4, 32'h10101010);
    ln(4, 16'd0, 16'd1, 16'd2, 16'd3, 32'd50, 32'd51, 32'd52, 32'd53);
    v(0,1,0,0,0, 16'd0, 32'd0,   1,1,0, 32'd4, 32'h0);
    v(0,1,0,1,1, 16'd4, 32'd54,  1,1,0, 32'd4, 32'h0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,1,1, 32'd5, 32'h00000010);
    ln(4, 16'd0, 16'd0, 16'd0, 16'd0, 32'd54, 32'd0, 32'd0, 32'd0);
    v(0,1,0,0,0, 16'd0, 32'd0,   0,0,0, 32'd5, 32'h0);

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ena, vecs[i].start, vecs[i].iv, vecs[i].il,
            vecs[i].dst, vecs[i].val);
      #1;
      applied++;
      cmp("in_ready", i, {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      cmp("busy", i, {31'd0, busy}, {31'd0, vecs[i].busy});
      cmp("done", i, {31'd0, done}, {31'd0, vecs[i].done});
      cmp("edge_count", i, edge_count, vecs[i].cnt);
      cmp("valid_mask", i, vmask, vecs[i].vm);
      if (vecs[i].chk) begin
        for (int l = 0; l < 4; l++) begin
          esrc = vecs[i].vm[8*l + vecs[i].fam] ? (vecs[i].evl[l][15:0] ^ 16'h5a5a) : 16'h0000;
          cmp("lane_dst", i, {16'd0, dst_all[l][16*vecs[i].fam +: 16]}, {16'd0, vecs[i].edst[l]});
          cmp("lane_value", i, val_all[l][32*vecs[i].fam +: 32], vecs[i].evl[l]);
          cmp("lane_src", i, {16'd0, src_all[l][16*vecs[i].fam +: 16]}, {16'd0, esrc});
        end
      end
    end

    // Hand sequence: ena drops during the DONE cycle, flush is held until ena returns.
    @(negedge clk); drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 32'd0);
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd7, 32'd70);
    #1; applied++;
    cmp("hs_ready", 100, {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
      #1; applied++;
      cmp("hs_done_low", 101 + k, {31'd0, done}, 32'd0);
      cmp("hs_busy_low", 101 + k, {31'd0, busy}, 32'd1);
      cmp("hs_valid_low", 101 + k, vmask, 32'h0);
    end
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
    #1; applied++;
    cmp("hs_done", 103, {31'd0, done}, 32'd1);
    cmp("hs_valid", 103, vmask, 32'h00000080);
    cmp("hs_value", 103, value0[32*7 +: 32], 32'd70);
    cmp("hs_count", 103, edge_count, 32'd1);
    @(negedge clk);
    #1; applied++;
    cmp("hs_idle_busy", 104, {31'd0, busy}, 32'd0);
    cmp("hs_idle_done", 104, {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
